hdmi_stream_ctrl: RTL and testbench
===================================

Name: hdmi_stream_ctrl

Overview:
- Sequences the pixel datapath that drives the HDMI output stream (hdmi_vs / hdmi_de / hdmi_data).
- Generates raster timing and pulls RGB pixels from an upstream valid/ready source, one pixel per active cycle.
- Aligns upstream frames to the raster using a start-of-frame marker.
- Reports underflow and misalignment, and stops only on frame boundaries.

Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACT, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level
- VS_POL, 0, vsync asserted level (board convention: active-low)

Ports:
- hdmi_clk  in  1  pixel clock
- hdmi_rst_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  run request; sampled at frame boundaries
- pix_data  in  24  upstream pixel {R,G,B}
- pix_sof  in  1  marks first pixel of an upstream frame
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- hdmi_vs  out  1  vertical sync
- hdmi_hs  out  1  horizontal sync
- hdmi_de  out  1  data enable
- hdmi_data  out  32  {8'h00,R,G,B}
- stat_clr  in  1  clears the sticky status flags
- underflow  out  1  sticky: active pixel had no valid data
- resync  out  1  sticky: SOF misaligned, controller re-entered SYNC
- frame_cnt  out  8  count of completed RUN frames, wraps 255->0

Behaviour:
- Reset: state IDLE; h_cnt=v_cnt=0; hdmi_de=0; hdmi_data=0; hdmi_hs=!HS_POL; hdmi_vs=!VS_POL; pix_ready=0; underflow=resync=0; frame_cnt=0.
- Counters: h_cnt 0..H_TOT-1 (H_TOT = sum of H params); v_cnt increments when h_cnt wraps, range 0..V_TOT-1. Counters hold at 0 in IDLE and run freely in SYNC and RUN.
- Decode: active = h<H_ACT && v<V_ACT. HS asserted for H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC. VS asserted for V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC, whole lines.
- Frame end (fe) = h==H_TOT-1 && v==V_TOT-1. Frame start (fs) = h==0 && v==0.
- pix_ready is combinational from counters and state. All sync/de/data outputs are registered: one-cycle latency from the counter position, so an accepted pixel appears on hdmi_data with hdmi_de=1 in the next cycle.
- IDLE: pix_ready=0. If enable=1, go to SYNC; counting starts at (0,0) on the next cycle.
- SYNC:
  - Timing runs; hdmi_de=0 throughout.
  - Away from fs: pix_ready = !pix_sof, so non-SOF beats are dropped and a SOF beat is held.
  - At fs with pix_valid & pix_sof: pix_ready=1, the pixel is accepted, go to RUN.
  - At fe with enable=0: go to IDLE.
- RUN:
  - pix_ready = active && !(pix_sof && !fs) && !(fs && !pix_sof).
  - Active cycle, accepted: de=1, data = pixel.
  - Active cycle, pix_valid=0: de=1, data=0 (black), set underflow; stay in RUN.
  - Active cycle, pix_valid=1 but SOF misplaced (SOF away from fs, or non-SOF at fs): beat not accepted, de=1, data=0, set resync, go to SYNC.
  - At fe: frame_cnt+1; go to IDLE if enable=0, else stay in RUN.
- enable deasserted mid-frame: the current frame completes (outputs unaffected), then IDLE at fe.
- Status flags: stat_clr clears them; if set and clear events coincide, set wins.
- Blanking: hdmi_data=0 whenever de=0.

Decomposition:
- Shared package vp_video_pkg:
  - state enum {IDLE,SYNC,RUN};
  - 640x480 timing constants;
  - pixel width (24);
  - stream data width (32).
- Sub-module video_timing_cnt: h/v counters, active/hs/vs/fs/fe decode, run/clear input.

Test Plan (small timing: H_ACT=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACT=3,V_FP=1,V_SYNC=1,V_BP=1):
- Reset, enable=0 -> hdmi_de=0, hdmi_hs=1, hdmi_vs=1, pix_ready=0 indefinitely.
- enable=1; source always valid with SOF on first of 12 pixels 0x000001..0x00000C -> first frame captures all 12 in raster order, de high 4 cycles/line on 3 lines, hs low 2 cycles/line, vs low 1 line; frame_cnt=1 after fe.
- Drop pix_valid for 1 active cycle -> that pixel is 0x00000000 with de=1, underflow=1; the next source pixel appears in the following slot; stat_clr clears the flag.
- Source SOF arrives at pixel 5 of the frame -> black from pixel 5 to frame end, resync=1, state SYNC; the held SOF is accepted at the next fs, and that frame is clean.
- enable deasserted mid-frame -> frame completes, IDLE at fe, pix_ready=0, counters at 0.
- hdmi_rst_n asserted mid-line -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vp_video_pkg.sv
// Shared video pipeline definitions: controller states, default 640x480 raster
// timing and the pixel/stream widths.
package vp_video_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_e;

   localparam int H_ACT_640 = 640;
   localparam int H_FP_640  = 16;
   localparam int H_SYNC_640 = 96;
   localparam int H_BP_640  = 48;
   localparam int V_ACT_480 = 480;
   localparam int V_FP_480  = 10;
   localparam int V_SYNC_480 = 2;
   localparam int V_BP_480  = 33;

   localparam int PIX_W    = 24;
   localparam int STREAM_W = 32;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Free-running raster counters with active/sync/frame-edge decode; counters are
// held at the origin while run_i is low.
module video_timing_cnt
   import vp_video_pkg::*;
#(
   parameter int H_ACT  = H_ACT_640,
   parameter int H_FP   = H_FP_640,
   parameter int H_SYNC = H_SYNC_640,
   parameter int H_BP   = H_BP_640,
   parameter int V_ACT  = V_ACT_480,
   parameter int V_FP   = V_FP_480,
   parameter int V_SYNC = V_SYNC_480,
   parameter int V_BP   = V_BP_480
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,
   output logic active_o,
   output logic hs_o,
   output logic vs_o,
   output logic fs_o,
   output logic fe_o
);

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HW    = cnt_w(H_TOT);
   localparam int VW    = cnt_w(V_TOT);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
   localparam logic [HW-1:0] HS_START = HW'(H_ACT + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_START = VW'(V_ACT + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          h_wrap, v_wrap;

   assign h_wrap = (h_cnt_q == H_LAST);
   assign v_wrap = (v_cnt_q == V_LAST);

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!run_i) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_wrap) begin
         h_cnt_d = '0;
         v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      end else begin
         h_cnt_d = h_cnt_q + HW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Sync windows cover whole lines for vsync, so vs ignores the h position.
   assign active_o = (h_cnt_q < HW'(H_ACT)) && (v_cnt_q < VW'(V_ACT));
   assign hs_o     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
   assign vs_o     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
   assign fs_o     = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign fe_o     = h_wrap && v_wrap;

endmodule

// File: rtl/hdmi_stream_ctrl.sv
// HDMI output sequencer: pulls pixels from a valid/ready source, locks upstream
// frames to the raster on SOF and reports underflow / misalignment.
module hdmi_stream_ctrl
   import vp_video_pkg::*;
#(
   parameter int   H_ACT  = H_ACT_640,
   parameter int   H_FP   = H_FP_640,
   parameter int   H_SYNC = H_SYNC_640,
   parameter int   H_BP   = H_BP_640,
   parameter int   V_ACT  = V_ACT_480,
   parameter int   V_FP   = V_FP_480,
   parameter int   V_SYNC = V_SYNC_480,
   parameter int   V_BP   = V_BP_480,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0
) (
   input  logic                hdmi_clk,
   input  logic                hdmi_rst_n,
   input  logic                enable,
   input  logic [PIX_W-1:0]    pix_data,
   input  logic                pix_sof,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic                hdmi_vs,
   output logic                hdmi_hs,
   output logic                hdmi_de,
   output logic [STREAM_W-1:0] hdmi_data,
   input  logic                stat_clr,
   output logic                underflow,
   output logic                resync,
   output logic [7:0]          frame_cnt,
   output state_e              dbg_state
);

   state_e              state_q, state_d;
   logic                de_q, de_d;
   logic [STREAM_W-1:0] data_q, data_d;
   logic                hs_q, vs_q;
   logic                underflow_q, resync_q;
   logic [7:0]          frame_cnt_q;
   logic                uf_set, rs_set, fc_inc;
   logic                active, hs_act, vs_act, fs, fe;
   logic                accept;

   video_timing_cnt #(
      .H_ACT (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACT (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk_i    (hdmi_clk),
      .rst_ni   (hdmi_rst_n),
      .run_i    (state_q != IDLE),
      .active_o (active),
      .hs_o     (hs_act),
      .vs_o     (vs_act),
      .fs_o     (fs),
      .fe_o     (fe)
   );

   // A beat transfers when pix_valid && pix_ready; pix_ready never depends on
   // pix_valid. While searching, non-SOF beats are drained and a SOF beat is
   // held until the raster origin.
   always_comb begin
      pix_ready = 1'b0;
      case (state_q)
         SYNC:    pix_ready = fs || !pix_sof;
         RUN:     pix_ready = active && !(pix_sof && !fs) && !(fs && !pix_sof);
         default: pix_ready = 1'b0;
      endcase
   end

   assign accept = pix_valid && pix_ready;

   always_comb begin
      state_d = state_q;
      de_d    = 1'b0;
      data_d  = '0;
      uf_set  = 1'b0;
      rs_set  = 1'b0;
      fc_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = SYNC;
         end
         SYNC: begin
            // The locking SOF pixel is displayed in its own slot.
            if (fs && accept && pix_sof) begin
               state_d = RUN;
               de_d    = 1'b1;
               data_d  = {{(STREAM_W - PIX_W){1'b0}}, pix_data};
            end else if (fe && !enable) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (active) begin
               de_d = 1'b1;
               if (accept) begin
                  data_d = {{(STREAM_W - PIX_W){1'b0}}, pix_data};
               end else if (!pix_valid) begin
                  uf_set = 1'b1;
               end else begin
                  rs_set  = 1'b1;
                  state_d = SYNC;
               end
            end
            if (fe) begin
               fc_inc = 1'b1;
               if (!enable) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
      if (!hdmi_rst_n) begin
         state_q     <= IDLE;
         de_q        <= 1'b0;
         data_q      <= '0;
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         underflow_q <= 1'b0;
         resync_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         de_q        <= de_d;
         data_q      <= data_d;
         hs_q        <= hs_act ? HS_POL : ~HS_POL;
         vs_q        <= vs_act ? VS_POL : ~VS_POL;
         underflow_q <= uf_set | (underflow_q & ~stat_clr);
         resync_q    <= rs_set | (resync_q & ~stat_clr);
         if (fc_inc) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign hdmi_de   = de_q;
   assign hdmi_data = data_q;
   assign hdmi_hs   = hs_q;
   assign hdmi_vs   = vs_q;
   assign underflow = underflow_q;
   assign resync    = resync_q;
   assign frame_cnt = frame_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hdmi_stream_ctrl.sv
// Directed bench for hdmi_stream_ctrl on a reduced 8x6 raster (4x3 active).
module tb_hdmi_stream_ctrl;
   import vp_video_pkg::*;

   logic        hdmi_clk   = 1'b0;
   logic        hdmi_rst_n = 1'b1;
   logic        enable     = 1'b0;
   logic [23:0] pix_data   = '0;
   logic        pix_sof    = 1'b0;
   logic        pix_valid  = 1'b0;
   logic        stat_clr   = 1'b0;
   logic        pix_ready, hdmi_vs, hdmi_hs, hdmi_de;
   logic [31:0] hdmi_data;
   logic        underflow, resync;
   logic [7:0]  frame_cnt;
   state_e      dbg_state;

   int checks = 0;
   int errors = 0;
   int de_n = 0, hs_n = 0, vs_n = 0, ready_n = 0;
   logic [31:0] exp_q[$];
   logic [25:0] src_q[$];   // {valid, sof, data}; valid=0 entries are one-cycle bubbles
   logic        adv = 1'b0;

   hdmi_stream_ctrl #(
      .H_ACT (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACT (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL (1'b0), .VS_POL (1'b0)
   ) dut (
      .hdmi_clk   (hdmi_clk),
      .hdmi_rst_n (hdmi_rst_n),
      .enable     (enable),
      .pix_data   (pix_data),
      .pix_sof    (pix_sof),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .hdmi_vs    (hdmi_vs),
      .hdmi_hs    (hdmi_hs),
      .hdmi_de    (hdmi_de),
      .hdmi_data  (hdmi_data),
      .stat_clr   (stat_clr),
      .underflow  (underflow),
      .resync     (resync),
      .frame_cnt  (frame_cnt),
      .dbg_state  (dbg_state)
   );

   always #5 hdmi_clk = ~hdmi_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Source: handshake outcome sampled mid-cycle, queue advanced after the edge.
   always @(negedge hdmi_clk)
      adv = pix_valid ? pix_ready : (src_q.size() > 0 && !src_q[0][25]);

   always @(posedge hdmi_clk) begin
      #1;
      if (adv && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
         pix_valid = src_q[0][25];
         pix_sof   = src_q[0][24];
         pix_data  = src_q[0][23:0];
      end else begin
         pix_valid = 1'b0;
         pix_sof   = 1'b0;
         pix_data  = '0;
      end
   end

   // Scoreboard monitor.
   always @(negedge hdmi_clk) begin
      if (hdmi_de === 1'b1) begin
         de_n++;
         if (exp_q.size() == 0) chk("de_without_expected", 32'(exp_q.size()), 32'd1);
         else chk("pixel", hdmi_data, exp_q.pop_front());
      end else begin
         chk("blank_data", hdmi_data, 32'h0);
      end
      if (hdmi_hs === 1'b0) hs_n++;
      if (hdmi_vs === 1'b0) vs_n++;
      if (pix_ready === 1'b1) ready_n++;
   end

   task automatic push_beat(input logic vld, input logic sof, input logic [23:0] d,
                            input logic [31:0] shown);
      src_q.push_back({vld, sof, d});
      exp_q.push_back(shown);
   endtask

   task automatic wait_frame_cnt(input logic [7:0] v, input string tag);
      int n = 0;
      while (frame_cnt !== v && n < 400) begin
         @(negedge hdmi_clk);
         n++;
      end
      chk(tag, 32'(frame_cnt), 32'(v));
   endtask

   task automatic wait_state(input state_e s, input string tag);
      int n = 0;
      while (dbg_state !== s && n < 400) begin
         @(negedge hdmi_clk);
         n++;
      end
      chk(tag, 32'(dbg_state), 32'(s));
   endtask

   initial begin
      #1 hdmi_rst_n = 1'b0;
      repeat (3) @(posedge hdmi_clk);
      #2 hdmi_rst_n = 1'b1;

      // Frames A..D: clean, one bubble at slot 4, SOF early at slot 5, clean.
      for (int i = 1; i <= 12; i++) push_beat(1'b1, i == 1, 24'(i), 32'(i));
      push_beat(1'b1, 1'b1, 24'h101, 32'h101);
      push_beat(1'b1, 1'b0, 24'h102, 32'h102);
      push_beat(1'b1, 1'b0, 24'h103, 32'h103);
      push_beat(1'b0, 1'b0, 24'h0,   32'h0);
      for (int i = 4; i <= 11; i++) push_beat(1'b1, 1'b0, 24'h100 + 24'(i), 32'h100 + 32'(i));
      for (int i = 1; i <= 4; i++) push_beat(1'b1, i == 1, 24'h200 + 24'(i), 32'h200 + 32'(i));
      exp_q.push_back(32'h0);
      for (int i = 1; i <= 12; i++) push_beat(1'b1, i == 1, 24'h300 + 24'(i), 32'h300 + 32'(i));

      hs_n = 0; vs_n = 0; ready_n = 0;
      repeat (12) @(negedge hdmi_clk);
      chk("idle_de", 32'(hdmi_de), 32'd0);
      chk("idle_hs", 32'(hdmi_hs), 32'd1);
      chk("idle_vs", 32'(hdmi_vs), 32'd1);
      chk("idle_ready", 32'(pix_ready), 32'd0);
      chk("idle_underflow", 32'(underflow), 32'd0);
      chk("idle_resync", 32'(resync), 32'd0);
      chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'(IDLE));
      @(posedge hdmi_clk); #1;
      chk("idle_hs_low_cycles", 32'(hs_n), 32'd0);
      chk("idle_vs_low_cycles", 32'(vs_n), 32'd0);
      chk("idle_ready_cycles", 32'(ready_n), 32'd0);

      // Frame A: raster shape and capture order.
      #1 enable = 1'b1;
      de_n = 0; hs_n = 0; vs_n = 0;
      wait_frame_cnt(8'd1, "frame_a_done");
      @(posedge hdmi_clk); #1;
      chk("frame_a_de_cycles", 32'(de_n), 32'd12);
      chk("frame_a_hs_low_cycles", 32'(hs_n), 32'd12);
      chk("frame_a_vs_low_cycles", 32'(vs_n), 32'd8);
      chk("frame_a_remaining_exp", 32'(exp_q.size()), 32'd29);
      chk("frame_a_underflow", 32'(underflow), 32'd0);

      // Frame B: one bubble produces a black slot and sets underflow.
      wait_frame_cnt(8'd2, "frame_b_done");
      chk("frame_b_underflow", 32'(underflow), 32'd1);
      chk("frame_b_resync", 32'(resync), 32'd0);
      @(posedge hdmi_clk); #2 stat_clr = 1'b1;
      @(posedge hdmi_clk); #2 stat_clr = 1'b0;
      @(negedge hdmi_clk);
      chk("stat_clr_underflow", 32'(underflow), 32'd0);

      // Frame C: early SOF forces a resync; frame D locks on the held SOF.
      begin
         int n = 0;
         while (resync !== 1'b1 && n < 400) begin
            @(negedge hdmi_clk);
            n++;
         end
      end
      chk("frame_c_resync", 32'(resync), 32'd1);
      chk("frame_c_state", 32'(dbg_state), 32'(SYNC));
      chk("frame_c_not_counted", 32'(frame_cnt), 32'd2);
      wait_state(RUN, "frame_d_locked");
      chk("frame_d_start_cnt", 32'(frame_cnt), 32'd2);

      // Disable mid-frame D: the frame still completes.
      repeat (10) @(posedge hdmi_clk);
      #2 enable = 1'b0;
      wait_frame_cnt(8'd3, "frame_d_done");
      @(posedge hdmi_clk); #1;
      chk("stop_state", 32'(dbg_state), 32'(IDLE));
      chk("stop_ready", 32'(pix_ready), 32'd0);
      chk("stop_all_shown", 32'(exp_q.size()), 32'd0);
      chk("frame_d_clean", 32'(underflow), 32'd0);
      hs_n = 0; vs_n = 0; ready_n = 0;
      repeat (20) @(negedge hdmi_clk);
      @(posedge hdmi_clk); #1;
      chk("stopped_hs_low_cycles", 32'(hs_n), 32'd0);
      chk("stopped_vs_low_cycles", 32'(vs_n), 32'd0);
      chk("stopped_ready_cycles", 32'(ready_n), 32'd0);

      // Asynchronous reset in the middle of an active line.
      for (int i = 1; i <= 12; i++) push_beat(1'b1, i == 1, 24'h400 + 24'(i), 32'h400 + 32'(i));
      @(posedge hdmi_clk); #2 enable = 1'b1;
      wait_state(RUN, "frame_f_locked");
      @(posedge hdmi_clk); #3 hdmi_rst_n = 1'b0;
      #1;
      chk("rst_de", 32'(hdmi_de), 32'd0);
      chk("rst_data", hdmi_data, 32'h0);
      chk("rst_hs", 32'(hdmi_hs), 32'd1);
      chk("rst_vs", 32'(hdmi_vs), 32'd1);
      chk("rst_ready", 32'(pix_ready), 32'd0);
      chk("rst_resync", 32'(resync), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      exp_q.delete();
      src_q.delete();
      enable = 1'b0;
      @(posedge hdmi_clk); #2 hdmi_rst_n = 1'b1;
      repeat (3) @(negedge hdmi_clk);
      chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

endmodule
